// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the conv layer input-path control logic.
//   seq_state_t : frame sequencer FSM encoding (IDLE/STREAM/DRAIN/DONE)
//   OUT_W/OUT_H : valid conv output windows per row / per column (defaults)
//   OUT_TOTAL   : valid conv output windows per frame (defaults)
//   out_total() : same product for arbitrary frame/kernel geometry
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int IMG_W_DEF    = 32;
  localparam int IMG_H_DEF    = 32;
  localparam int KERNEL_DEF   = 5;
  localparam int CONV_FILTERS = 8;

  localparam int OUT_W     = IMG_W_DEF - KERNEL_DEF + 1;
  localparam int OUT_H     = IMG_H_DEF - KERNEL_DEF + 1;
  localparam int OUT_TOTAL = OUT_W * OUT_H;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  // Number of valid (no padding) output windows for a WxH frame, KxK kernel.
  function automatic int out_total(input int w, input int h, input int k);
    return (w - k + 1) * (h - k + 1);
  endfunction

endpackage

// File: rtl/conv_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer_if
// Pixel handshake and conv-engine status bundle around the frame sequencer.
//   pix_valid       : upstream pixel present
//   pix_ready       : sequencer accepts the pixel this cycle
//   conv_feat_valid : qualifier to the conv engine feature input
//   conv_buf_full   : conv line-buffer backpressure
//   conv_out_valid  : one pulse per conv output window
// Handshake: a pixel transfers on every clk edge where pix_valid and
// pix_ready are both high; pix_ready does not depend on pix_valid, and
// conv_feat_valid is exactly that transfer condition.
// master = pixel source / conv engine side, slave = sequencer.
// -----------------------------------------------------------------------------
interface conv_frame_sequencer_if;
  logic pix_valid;
  logic pix_ready;
  logic conv_feat_valid;
  logic conv_buf_full;
  logic conv_out_valid;

  modport master (
    output pix_valid, conv_buf_full, conv_out_valid,
    input  pix_ready, conv_feat_valid
  );

  modport slave (
    input  pix_valid, conv_buf_full, conv_out_valid,
    output pix_ready, conv_feat_valid
  );
endinterface

// File: rtl/frame_pos_counter.sv
// -----------------------------------------------------------------------------
// frame_pos_counter
// Raster row/column position counter for a WxH frame. Also usable for the
// output feature-map stream.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clear    : return to (0,0)
//   i_inc      : advance one position; holds at the last position
//   o_row      : current row
//   o_col      : current column
//   o_last     : current position is (IMG_H-1, IMG_W-1)
// -----------------------------------------------------------------------------
module frame_pos_counter #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clear,
  input  logic                     i_inc,
  output logic [$clog2(IMG_H)-1:0] o_row,
  output logic [$clog2(IMG_W)-1:0] o_col,
  output logic                     o_last
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_col_end;

  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign o_last    = w_col_end && (r_row == RW'(IMG_H - 1));
  assign o_row     = r_row;
  assign o_col     = r_col;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc && !o_last) begin
      // The final position is held so it stays visible after the frame.
      if (w_col_end) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/conv_frame_sequencer.sv
// -----------------------------------------------------------------------------
// conv_frame_sequencer
// Frame-level controller for the conv layer input path. Gates pixel
// acceptance against conv line-buffer backpressure, tracks the position of
// the next pixel, counts conv output windows and pulses frame_done once the
// whole frame has been produced.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : one-cycle frame request, honoured only in IDLE
//   seq_if (slave)  : pixel handshake + conv status (see interface file)
//   row_idx/col_idx : position of the next pixel to accept
//   out_count       : conv outputs seen this frame (saturates at OUT_TOTAL)
//   busy            : high in STREAM and DRAIN
//   frame_done      : one-cycle pulse in DONE
//   overrun_err     : sticky, unexpected/extra conv output seen
//   timeout_err     : sticky, DRAIN watchdog expired (CONV_SEQ_TIMEOUT_EN)
//   dbg_state       : current FSM state
// Optional feature macro: CONV_SEQ_TIMEOUT_EN adds the DRAIN watchdog,
// the TIMEOUT_CYC parameter and the timeout_err port.
// -----------------------------------------------------------------------------
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter  int IMG_W       = IMG_W_DEF,
  parameter  int IMG_H       = IMG_H_DEF,
  parameter  int KERNEL      = KERNEL_DEF,
`ifdef CONV_SEQ_TIMEOUT_EN
  parameter  int TIMEOUT_CYC = 4096,
`endif
  localparam int TOTAL       = out_total(IMG_W, IMG_H, KERNEL),
  localparam int CNT_W       = $clog2(TOTAL + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  conv_frame_sequencer_if.slave    seq_if,
  output logic [$clog2(IMG_H)-1:0] row_idx,
  output logic [$clog2(IMG_W)-1:0] col_idx,
  output logic [CNT_W-1:0]         out_count,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun_err,
`ifdef CONV_SEQ_TIMEOUT_EN
  output logic                     timeout_err,
`endif
  output seq_state_t               dbg_state
);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [CNT_W-1:0] r_out_count;
  logic             r_overrun_err;
  logic             w_pix_ready;
  logic             w_busy;
  logic             w_frame_done;
  logic             w_accept;
  logic             w_start_ok;
  logic             w_active;
  logic             w_cnt_full;
  logic             w_last;
  logic             w_to_hit;

  assign w_active   = (r_state == STREAM) || (r_state == DRAIN);
  assign w_start_ok = (r_state == IDLE) && start;
  assign w_accept   = seq_if.pix_valid && w_pix_ready;
  assign w_cnt_full = (r_out_count == CNT_W'(TOTAL));

  frame_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start_ok),
    .i_inc   (w_accept),
    .o_row   (row_idx),
    .o_col   (col_idx),
    .o_last  (w_last)
  );

`ifdef CONV_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout_err;

  assign w_to_hit    = (r_state == DRAIN) && (r_to_cnt == TO_W'(TIMEOUT_CYC));
  assign timeout_err = r_timeout_err;

  // Counts quiet DRAIN cycles; any conv output restarts the window.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state != DRAIN) || seq_if.conv_out_valid) begin
      r_to_cnt <= '0;
    end else if (!w_to_hit) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_to_hit && !w_cnt_full) begin
      r_timeout_err <= 1'b1;
    end else if (w_start_ok) begin
      r_timeout_err <= 1'b0;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = STREAM;
      STREAM:  if (w_accept && w_last) w_next_state = DRAIN;
      DRAIN:   if (w_cnt_full || w_to_hit) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_pix_ready  = 1'b0;
    w_busy       = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      STREAM: begin
        w_pix_ready = !seq_if.conv_buf_full;
        w_busy      = 1'b1;
      end
      DRAIN:   w_busy       = 1'b1;
      DONE:    w_frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_start_ok) begin
      r_out_count <= '0;
    end else if (w_active && seq_if.conv_out_valid && !w_cnt_full) begin
      r_out_count <= r_out_count + 1'b1;
    end
  end

  // Overrun: an output outside the frame window, an output at saturation,
  // or all outputs already produced while pixels are still streaming.
  // A set in the same cycle as start wins so the error is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun_err <= 1'b0;
    end else if ((seq_if.conv_out_valid && (!w_active || w_cnt_full)) ||
                 ((r_state == STREAM) && w_cnt_full)) begin
      r_overrun_err <= 1'b1;
    end else if (w_start_ok) begin
      r_overrun_err <= 1'b0;
    end
  end

  assign seq_if.pix_ready       = w_pix_ready;
  assign seq_if.conv_feat_valid = w_accept;
  assign out_count              = r_out_count;
  assign busy                   = w_busy;
  assign frame_done             = w_frame_done;
  assign overrun_err            = r_overrun_err;
  assign dbg_state              = r_state;

endmodule
